// File: rtl/screen_filler.sv
// screen_filler: paints every pixel of a WIDTH x HEIGHT rectangle at
// (X_ORIGIN, Y_ORIGIN). Colour comes from a constant fill colour or from
// one of NUM_SRC external image ROMs with 1-cycle read latency.
//
// Optional build macro: SCREEN_FILLER_BORDER_EN -- the outermost ring of
// the rectangle is painted BORDER_COLOUR regardless of the source.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         paint request, only sampled while idle
//   sel           0 = FILL_COLOUR, k = ROM k-1; latched on accepted start
//   hold          back-pressure, freezes the walk and suppresses plot
//   src_colour    ROM q buses, source k at [k*COLOUR_W +: COLOUR_W]
//   rom_address   shared ROM read address (0 when idle/done)
//   xLoc, yLoc    pixel coordinate, 0 while plot is low
//   colour        pixel colour, 0 while plot is low
//   plot          write strobe for the VGA adapter
//   busy          high from accepted start until done
//   done          one-cycle pulse after the final pixel
module screen_filler #(
  parameter int X_ORIGIN = 80,
  parameter int Y_ORIGIN = 0,
  parameter int WIDTH    = 240,
  parameter int HEIGHT   = 240,
  parameter int XY_W     = 9,
  parameter int COLOUR_W = 3,
  parameter int NUM_SRC  = 3,
  parameter int ADDR_W   = 16,
  parameter int SEL_W    = 2,
  parameter logic [COLOUR_W-1:0] FILL_COLOUR   = 3'b001,
  parameter logic [COLOUR_W-1:0] BORDER_COLOUR = 3'b111
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [SEL_W-1:0]             sel,
  input  logic                         hold,
  input  logic [NUM_SRC*COLOUR_W-1:0]  src_colour,
  output logic [ADDR_W-1:0]            rom_address,
  output logic [XY_W-1:0]              xLoc,
  output logic [XY_W-1:0]              yLoc,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot,
  output logic                         busy,
  output logic                         done
);

  localparam int CX_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int CY_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

`ifdef SCREEN_FILLER_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  // One pipeline stage, aligned with the ROM read latency.
  typedef struct packed {
    logic            vld;
    logic            border;
    logic [XY_W-1:0] x;
    logic [XY_W-1:0] y;
  } pix_t;

  state_t              state, state_n;
  logic [CX_W-1:0]     countx;
  logic [CY_W-1:0]     county;
  logic [ADDR_W-1:0]   addr;
  logic [SEL_W-1:0]    sel_q;
  pix_t                pipe;
  logic                issue, last;
  logic [COLOUR_W-1:0] live, held_col, pix_col;
  logic                held_v;

  assign last = (countx == CX_W'(WIDTH-1)) && (county == CY_W'(HEIGHT-1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (!hold) begin
                 issue = 1'b1;
                 if (last) state_n = S_FLUSH;
               end
      S_FLUSH: if (!hold) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Source mux; out-of-range selects fall back to the fill colour.
  always_comb begin
    live = FILL_COLOUR;
    for (int k = 0; k < NUM_SRC; k++)
      if (sel_q == SEL_W'(k+1)) live = src_colour[k*COLOUR_W +: COLOUR_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      countx   <= '0;
      county   <= '0;
      addr     <= '0;
      sel_q    <= '0;
      pipe     <= '0;
      held_v   <= 1'b0;
      held_col <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        sel_q  <= sel;
        countx <= '0;
        county <= '0;
        addr   <= '0;
      end
      if (issue) begin
        pipe.vld    <= 1'b1;
        pipe.border <= (countx == '0) || (countx == CX_W'(WIDTH-1)) ||
                       (county == '0) || (county == CY_W'(HEIGHT-1));
        pipe.x      <= XY_W'(X_ORIGIN) + XY_W'(countx);
        pipe.y      <= XY_W'(Y_ORIGIN) + XY_W'(county);
        // The last address stays put through FLUSH.
        if (!last) begin
          addr <= addr + 1'b1;
          if (countx == CX_W'(WIDTH-1)) begin
            countx <= '0;
            county <= county + 1'b1;
          end else begin
            countx <= countx + 1'b1;
          end
        end
      end else if (state == S_FLUSH && !hold) begin
        pipe.vld <= 1'b0;
      end
      // The ROM keeps reading the frozen (next) address during hold, so its
      // q is only valid for the pending pixel on the first hold cycle.
      // Capture it there and replay it when hold releases.
      if (pipe.vld && hold) begin
        if (!held_v) begin
          held_v   <= 1'b1;
          held_col <= live;
        end
      end else begin
        held_v <= 1'b0;
      end
    end
  end

  assign pix_col     = held_v ? held_col : live;
  assign plot        = pipe.vld & ~hold;
  assign busy        = (state == S_RUN) || (state == S_FLUSH);
  assign done        = (state == S_DONE);
  assign rom_address = busy ? addr : '0;
  assign xLoc        = plot ? pipe.x : '0;
  assign yLoc        = plot ? pipe.y : '0;
  assign colour      = !plot ? '0 :
                       (BORDER_EN && pipe.border) ? BORDER_COLOUR : pix_col;

endmodule

// File: tb/tb_screen_filler.sv
module tb_screen_filler;
  localparam int XO = 10, YO = 5, W = 6, H = 5, N = W*H;
  localparam int XW = 9, CW = 3, NS = 2, AW = 5, SW = 2;
  localparam logic [2:0] FILL = 3'b001, BORD = 3'b111;

  logic clk = 1'b0;
  logic reset, start, hold;
  logic [SW-1:0]    sel;
  logic [NS*CW-1:0] src_colour;
  logic [AW-1:0]    rom_address;
  logic [XW-1:0]    xLoc, yLoc;
  logic [CW-1:0]    colour;
  logic             plot, busy, done;
  logic [CW-1:0]    rom_q [NS];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  screen_filler #(
    .X_ORIGIN(XO), .Y_ORIGIN(YO), .WIDTH(W), .HEIGHT(H), .XY_W(XW),
    .COLOUR_W(CW), .NUM_SRC(NS), .ADDR_W(AW), .SEL_W(SW),
    .FILL_COLOUR(FILL), .BORDER_COLOUR(BORD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .hold(hold),
    .src_colour(src_colour), .rom_address(rom_address), .xLoc(xLoc),
    .yLoc(yLoc), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  // Image ROM k: contents are an arbitrary function of address, 1-cycle latency.
  function automatic logic [2:0] rom_f(input int k, input int a);
    return 3'((a*(2*k+3) + (a >> 2) + k) & 7);
  endfunction

  always @(posedge clk)
    for (int k = 0; k < NS; k++) rom_q[k] <= rom_f(k, int'(rom_address));

  assign src_colour = {rom_q[1], rom_q[0]};

  // Expected colour of raster pixel i for a paint started with select s.
  function automatic logic [2:0] exp_col(input int s, input int i);
    int x, y;
    x = i % W;
    y = i / W;
`ifdef SCREEN_FILLER_BORDER_EN
    if (x == 0 || x == W-1 || y == 0 || y == H-1) return BORD;
`endif
    if (x < 0 || y < 0) return 3'b000;
    if (s >= 1 && s <= NS) return rom_f(s-1, i);
    return FILL;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then sample on the falling edge.
  task automatic cyc_in(input logic st, input logic [SW-1:0] sl, input logic hd);
    @(posedge clk);
    #1;
    start = st;
    sel   = sl;
    hold  = hd;
    @(negedge clk);
  endtask

  task automatic paint(input int s, input int hold_pct, input bit noisy, input int abort_at);
    int  plots = 0;
    int  nh    = 0;
    int  first = -1;
    bit  fin   = 1'b0;
    cyc_in(1'b1, SW'(s), 1'b0);
    chk("busy_c0", busy, 0);
    for (int c = 1; c <= 3*N + 40 && !fin; c++) begin
      logic hd, st;
      logic [SW-1:0] sl;
      hd = ($urandom_range(0, 99) < hold_pct);
      st = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      sl = noisy ? SW'($urandom) : SW'(s);
      cyc_in(st, sl, hd);
      if (c == 1) chk("busy_c1", busy, 1);
      // Address of the next pixel to issue = non-hold busy cycles so far.
      if (busy && nh < N) chk("rom_address", rom_address, nh);
      if (plot) begin
        chk("plot_in_hold", hd, 0);
        if (plots >= N) chk("extra_plot", plots, N-1);
        else begin
          chk("xLoc",   xLoc,   XO + plots % W);
          chk("yLoc",   yLoc,   YO + plots / W);
          chk("colour", colour, exp_col(s, plots));
        end
        if (first < 0) first = c;
        plots++;
        if (abort_at > 0 && plots == abort_at) begin
          @(posedge clk); #1 reset = 1'b1; start = 1'b0; hold = 1'b0;
          @(posedge clk); #1 reset = 1'b0;
          @(negedge clk);
          chk("abort_outs", {rom_address, xLoc, yLoc, colour, plot, busy, done}, 0);
          return;
        end
      end else begin
        chk("quiet_outs", {xLoc, yLoc, colour}, 0);
      end
      if (busy && !hd) nh++;
      if (done) begin
        chk("busy_at_done", busy, 0);
        chk("busy_cycles", nh, N+1);
        chk("plots", plots, N);
        if (hold_pct == 0) begin
          chk("first_plot_cyc", first, 2);
          chk("done_cyc", c, N+2);
        end
        fin = 1'b1;
      end
    end
    if (!fin) chk("done_timeout", 0, 1);
    repeat (3) begin
      cyc_in(1'b0, SW'($urandom), 1'($urandom_range(0, 1)));
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_addr", rom_address, 0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0; sel = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outs", {rom_address, xLoc, yLoc, colour, plot, busy, done}, 0);
    @(posedge clk); #1 reset = 1'b0;

    paint(0, 0,  1'b0, 0);   // fill colour, exact timing
    paint(1, 0,  1'b0, 0);   // ROM 0
    paint(2, 30, 1'b1, 0);   // ROM 1, hold, start/sel noise
    paint(3, 30, 1'b0, 0);   // out-of-range select -> fill
    paint(1, 20, 1'b0, 7);   // reset mid-paint
    paint(2, 0,  1'b0, 0);   // repaint from origin after abort
    paint(2, 50, 1'b1, 0);
    for (int i = 0; i < 6; i++)
      paint(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
